// File: rtl/spram_init_clr.sv
// spram_init_clr: parametrised single-port RAM with per-nibble write masks,
// a registered read port with selectable read-during-write response, and a
// sequential clear engine that writes INIT_VAL to every word after reset or
// on a clr request.
module spram_init_clr #(
    parameter int unsigned     DW       = 8,
    parameter int unsigned     AW       = 7,
    parameter int unsigned     RD_MODE  = 0,
    parameter logic [DW-1:0]   INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              req,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DW/4-1:0]   wmask,
    input  logic [DW-1:0]     wdata,
    output logic              ready,
    output logic              busy,
    output logic              rvalid,
    output logic [DW-1:0]     rdata
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned NL    = DW / 4;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [DW-1:0]   mem [DEPTH];
    logic [DW-1:0]   merged;
    logic            accept;

    // Requests are only taken while idle and no clear is being requested.
    assign busy   = (state == CLEAR);
    assign ready  = (state == IDLE) && !clr;
    assign accept = ready && req;

    // Word as it looks after the masked write: enabled nibbles replaced.
    always_comb begin
        merged = mem[addr];
        for (int unsigned k = 0; k < NL; k++) begin
            if (wmask[k]) begin
                merged[4*k +: 4] = wdata[4*k +: 4];
            end
        end
    end

    // Clear engine / access FSM; the terminal compare on cnt ends the sweep,
    // so the AW-bit counter never needs to represent DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else if (clr) begin
            state <= CLEAR;
            cnt   <= '0;
        end else if (state == CLEAR) begin
            if (cnt == '1) begin
                state <= IDLE;
            end
            cnt <= cnt + AW'(1);
        end
    end

    // Storage array: clear sweep writes INIT_VAL, accepted writes merge lanes.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= INIT_VAL;
        end else if (accept && we) begin
            mem[addr] <= merged;
        end
    end

    // Registered response port; rdata holds whenever no response is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= 1'b0;
            if (accept) begin
                if (!we) begin
                    rvalid <= 1'b1;
                    rdata  <= mem[addr];
                end else if (RD_MODE == 0) begin
                    rvalid <= 1'b1;
                    rdata  <= mem[addr];
                end else if (RD_MODE == 1) begin
                    rvalid <= 1'b1;
                    rdata  <= merged;
                end
            end
        end
    end

endmodule

// File: tb/tb_spram_init_clr.sv
// tb_spram_init_clr: drives three spram_init_clr instances (RD_MODE 0/1/2)
// with identical stimulus; a reference model predicts handshake and response
// data, a queue carries expected responses to a negedge monitor.
module tb_spram_init_clr;

    localparam int DEPTH = 16;
    localparam logic [7:0] INIT = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       req = 1'b0;
    logic       we = 1'b0;
    logic [3:0] addr = '0;
    logic [1:0] wmask = '0;
    logic [7:0] wdata = '0;
    logic [2:0] rdy, bsy, rv;
    logic [7:0] rdat [3];

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [2:0]      v;
        logic [2:0][7:0] d;
    } exp_t;
    exp_t expq[$];

    int         clear_left;
    logic [7:0] mem_m [DEPTH];
    logic [7:0] last_rd [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        spram_init_clr #(
            .DW(8), .AW(4), .RD_MODE(g), .INIT_VAL(INIT)
        ) u_dut (
            .clk(clk), .rst(rst), .clr(clr), .req(req), .we(we),
            .addr(addr), .wmask(wmask), .wdata(wdata),
            .ready(rdy[g]), .busy(bsy[g]), .rvalid(rv[g]), .rdata(rdat[g])
        );
    end

    function automatic void chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, idx, act, exp, $time);
        end
    endfunction

    // Response monitor: every negedge must match exactly what the model queued.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                chk("rst_rvalid", i, rv[i], 0);
                chk("rst_rdata", i, rdat[i], 0);
                last_rd[i] = 8'h00;
            end
        end else begin
            e = '0;
            if (expq.size() > 0) e = expq.pop_front();
            for (int i = 0; i < 3; i++) begin
                chk("rvalid", i, rv[i], e.v[i]);
                if (e.v[i]) begin
                    chk("rdata", i, rdat[i], e.d[i]);
                    last_rd[i] = e.d[i];
                end else begin
                    chk("rdata_hold", i, rdat[i], last_rd[i]);
                end
            end
        end
    end

    // One clock of stimulus; model advances at the posedge.
    task automatic cycle(input logic r, input logic w, input logic [3:0] a,
                         input logic [1:0] m, input logic [7:0] d, input logic c);
        logic       exp_ready;
        logic [7:0] oldw, neww;
        exp_t       e;
        req = r; we = w; addr = a; wmask = m; wdata = d; clr = c;
        @(negedge clk);
        exp_ready = (clear_left == 0) && !c;
        for (int i = 0; i < 3; i++) begin
            chk("ready", i, rdy[i], exp_ready);
            chk("busy", i, bsy[i], clear_left != 0);
        end
        @(posedge clk);
        if (exp_ready && r) begin
            oldw = mem_m[a];
            if (!w) begin
                e.v = 3'b111;
                e.d = {oldw, oldw, oldw};
            end else begin
                neww = oldw;
                for (int j = 0; j < 2; j++)
                    if (m[j]) neww[4*j +: 4] = d[4*j +: 4];
                mem_m[a] = neww;
                e.v = 3'b011;
                e.d = {8'h00, neww, oldw};
            end
            expq.push_back(e);
        end
        if (c) begin
            clear_left = DEPTH;
        end else if (clear_left > 0) begin
            clear_left--;
            if (clear_left == 0)
                for (int k = 0; k < DEPTH; k++) mem_m[k] = INIT;
        end
        #1;
    endtask

    initial begin
        clear_left = DEPTH;
        for (int i = 0; i < 3; i++) last_rd[i] = 8'h00;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("rst_ready", i, rdy[i], 0);
                chk("rst_busy", i, bsy[i], 1);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;

        // Clear after reset with req held high, then read every word.
        repeat (DEPTH + 2) cycle(1, 1, 4'd2, 2'b11, 8'h5A, 0);
        for (int a = 0; a < DEPTH; a++) cycle(1, 0, 4'(a), 2'b00, 8'h00, 0);

        // Masked writes.
        cycle(1, 1, 4'd3, 2'b01, 8'h3C, 0);
        cycle(1, 0, 4'd3, 2'b00, 8'h00, 0);
        cycle(1, 1, 4'd3, 2'b00, 8'hFF, 0);
        cycle(1, 0, 4'd3, 2'b00, 8'h00, 0);

        // Read-during-write response per mode.
        cycle(1, 1, 4'd5, 2'b11, 8'h11, 0);
        cycle(0, 0, 4'd0, 2'b00, 8'h00, 0);
        cycle(1, 1, 4'd5, 2'b11, 8'h77, 0);
        cycle(1, 0, 4'd5, 2'b00, 8'h00, 0);
        cycle(0, 0, 4'd0, 2'b00, 8'h00, 0);

        // Clear restarted mid-sweep with req held high.
        cycle(0, 0, 4'd0, 2'b00, 8'h00, 1);
        repeat (4) cycle(1, 1, 4'd6, 2'b11, 8'h42, 0);
        cycle(1, 0, 4'd6, 2'b00, 8'h00, 1);
        repeat (DEPTH + 2) cycle(1, 0, 4'd6, 2'b00, 8'h00, 0);

        // clr colliding with a write in idle.
        cycle(1, 1, 4'd0, 2'b11, 8'h00, 1);
        repeat (DEPTH) cycle(0, 0, 4'd0, 2'b00, 8'h00, 0);
        cycle(1, 0, 4'd0, 2'b00, 8'h00, 0);

        // Randomised traffic with occasional clears.
        repeat (600) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)), $urandom_range(0, 63) == 0);
        end
        repeat (DEPTH + 1) cycle(0, 0, 4'd0, 2'b00, 8'h00, 0);

        // Back-to-back reads, then async reset mid-stream.
        for (int a = 0; a < DEPTH; a++) cycle(1, 0, 4'(a), 2'b00, 8'h00, 0);
        for (int a = 0; a < 8; a++) cycle(1, 0, 4'(a), 2'b00, 8'h00, 0);
        #1;
        rst = 1'b0;
        expq.delete();
        #1;
        for (int i = 0; i < 3; i++) chk("rst_drop_rvalid", i, rv[i], 0);
        @(posedge clk); #1;
        rst = 1'b1;
        clear_left = DEPTH;
        repeat (DEPTH + 1) cycle(1, 0, 4'd9, 2'b00, 8'h00, 0);
        for (int a = 0; a < 8; a++) cycle(1, 0, 4'($urandom_range(0, 15)), 2'b00, 8'h00, 0);
        repeat (2) cycle(0, 0, 4'd0, 2'b00, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spram_init_clr.md
# spram_init_clr

Parametrised single-port RAM with per-nibble write masks, a registered read port with selectable read-during-write behaviour, and a built-in sequential clear engine. It replaces the fixed 128x4 single-port RAM for new datapaths. Its memory needs no reset fan-out: clearing is done one word per cycle after reset or on request. It sits between a requesting master (req/ready handshake) and any consumer of the rvalid/rdata response stream.

## Interface
- DW, default 8: data width in bits; must be a multiple of 4.
- AW, default 7: address width; DEPTH = 2**AW words.
- RD_MODE, default 0: read-during-write behaviour. 0 = read-first (old word returned), 1 = write-first (merged new word returned), 2 = no response on writes.
- INIT_VAL, default 0: DW-bit value written to every word by the clear engine.
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- clr, input, 1: synchronous clear request; sampled every cycle.
- req, input, 1: access request.
- we, input, 1: 1 = write, 0 = read; qualified by req.
- addr, input, AW: word address.
- wmask, input, DW/4: nibble write enables; bit k enables wdata[4k+3:4k].
- wdata, input, DW: write data.
- ready, output, 1: block can accept req this cycle.
- busy, output, 1: clear engine active.
- rvalid, output, 1: rdata valid this cycle (single-cycle pulse per response).
- rdata, output, DW: read response data.

## Operation
- FSM states are CLEAR and IDLE. Async reset forces CLEAR with clear counter = 0.
- **CLEAR state**
  - Each cycle writes INIT_VAL to mem[counter], then increments the counter.
  - When the counter reaches DEPTH-1 and that word is written, the FSM goes to IDLE.
  - busy = 1, ready = 0, and rvalid = 0 in CLEAR. req is ignored (not accepted).
- **IDLE state**
  - busy = 0.
  - ready = !clr (combinational). A transfer is accepted when req & ready.
  - Accepted read: rdata <= mem[addr] at that edge; rvalid = 1 for the next cycle.
  - Accepted write: for each lane k with wmask[k] = 1, mem[addr] lane k <= wdata lane k. Lanes with wmask[k] = 0 are unchanged. wmask = 0 still counts as an accepted write.
  - Write response by RD_MODE:
    - 0: rdata = pre-write word, rvalid pulses.
    - 1: rdata = merged post-write word, rvalid pulses.
    - 2: rvalid stays 0 and rdata holds.
- **clr in IDLE**
  - Counter <= 0, FSM <= CLEAR. A req in the same cycle is not accepted.
- **clr in CLEAR**
  - Counter restarts at 0. The clear sequence runs the full DEPTH cycles again.
- **Reset mid-operation**
  - Clear restarts from 0. Any pending rvalid is dropped. Memory contents are undefined until the clear completes.
- **Register behaviour**
  - rdata holds its last value whenever rvalid = 0.
  - Back-to-back accepted requests produce back-to-back rvalid pulses at full throughput.
- **Addressing**
  - Addresses use AW bits exactly; there is no out-of-range condition.
  - The clear counter is AW+1 bits wide or uses a terminal flag, so it never aliases to 0 before finishing.

## Timing
- Reset values: ready = 0, busy = 1, rvalid = 0, rdata = 0, state = CLEAR, counter = 0.
- Clear duration is exactly DEPTH rising edges after rst deasserts, or after the edge that samples clr.
  - Edge n (n = 1..DEPTH) writes address n-1.
  - ready = 1 in the cycle after edge DEPTH.
- Read latency is 1 cycle: req accepted at edge t gives rvalid/rdata valid between edges t and t+1.
- Read after write to the same address on consecutive accepted cycles returns the written data in all RD_MODEs.
- ready never depends on req; master may hold req high while ready = 0.

## Test plan
- **Reset and clear.** DW=8, AW=4, INIT_VAL=8'hA5; deassert rst.
  - busy = 1 for exactly 16 cycles, then ready = 1.
  - Reading all 16 addresses returns 8'hA5, with one rvalid per read at 1-cycle latency.
- **Masked write.** Write addr 3, wdata 8'h3C, wmask 2'b01 onto 8'hA5.
  - Read returns 8'hAC.
  - Repeat with wmask 2'b00: read still returns 8'hAC.
- **RD_MODE sweep.** Write 8'h77 (full mask) to a word holding 8'h11.
  - RD_MODE 0: write response rdata = 8'h11.
  - RD_MODE 1: write response rdata = 8'h77.
  - RD_MODE 2: no rvalid.
- **Clear while busy.** Pulse clr at cycle 5 of a clear and req held high throughout.
  - busy persists 16 cycles after the clr edge.
  - No transfer is accepted; no rvalid.
- **clr colliding with req in IDLE.** Assert clr and a write req to addr 0 (8'h00) together.
  - Write not accepted; ready = 0 that cycle.
  - After the clear, addr 0 reads INIT_VAL.
- **Back-to-back reads and async reset.** Read addresses 0..15 with req held high.
  - 16 consecutive rvalid cycles in order.
  - Asserting rst mid-stream drops rvalid to 0 immediately and restarts the clear.
